// File: rtl/alu_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_fsm_pkg
// Brief    : Opcode/funct encodings, FSM state codes and instruction-class
//            decode shared by the multicycle ALU control unit.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_fsm_pkg;

    localparam logic [5:0] c_OP_RFORMAT = 6'h00;
    localparam logic [5:0] c_OP_JUMP    = 6'h02;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_ADDI    = 6'h08;
    localparam logic [5:0] c_OP_SLTI    = 6'h0A;
    localparam logic [5:0] c_OP_FLPT    = 6'h11;
    localparam logic [5:0] c_OP_LDRW    = 6'h23;
    localparam logic [5:0] c_OP_STRW    = 6'h2B;

    localparam logic [5:0] c_FN_RSLL    = 6'h00;
    localparam logic [5:0] c_FN_RSRL    = 6'h02;
    localparam logic [5:0] c_FN_RMULT   = 6'h18;
    localparam logic [5:0] c_FN_RDIV    = 6'h1A;
    localparam logic [5:0] c_FN_RADD    = 6'h20;
    localparam logic [5:0] c_FN_RSUB    = 6'h22;
    localparam logic [5:0] c_FN_RSLT    = 6'h2A;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_DECODE  = 3'd1;
    localparam logic [2:0] c_ST_EXEC    = 3'd2;
    localparam logic [2:0] c_ST_MEM     = 3'd3;
    localparam logic [2:0] c_ST_WB      = 3'd4;
    localparam logic [2:0] c_ST_BRANCH  = 3'd5;
    localparam logic [2:0] c_ST_FPSTALL = 3'd6;

    localparam logic [1:0] c_PCSRC_NONE   = 2'b00;
    localparam logic [1:0] c_PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_FP,
        CLS_ILLEGAL
    } op_class_e;

    // Rformat is only legal for the seven implemented funct codes.
    function automatic op_class_e decode_class(input logic [5:0] opcode,
                                               input logic [5:0] funct);
        op_class_e cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            c_OP_RFORMAT: begin
                case (funct)
                    c_FN_RSLL, c_FN_RSRL, c_FN_RMULT, c_FN_RDIV,
                    c_FN_RADD, c_FN_RSUB, c_FN_RSLT: cls = CLS_ALU;
                    default:                         cls = CLS_ILLEGAL;
                endcase
            end
            c_OP_ADDI, c_OP_SLTI: cls = CLS_IMM;
            c_OP_LDRW:            cls = CLS_LOAD;
            c_OP_STRW:            cls = CLS_STORE;
            c_OP_BEQ, c_OP_BNE:   cls = CLS_BRANCH;
            c_OP_JUMP:            cls = CLS_JUMP;
            c_OP_FLPT:            cls = CLS_FP;
            default:              cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage : alu_ctrl_fsm_pkg
`default_nettype wire

// File: rtl/alu_ctrl_fsm_fp_stall_counter.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_fsm_fp_stall_counter
// Brief    : Loadable down-counter timing the floating-point stall window.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_fsm_fp_stall_counter #(
    parameter int FP_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam int c_CNT_W = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_CNT_W'(FP_LAT - 1);
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);

endmodule : alu_ctrl_fsm_fp_stall_counter
`default_nettype wire

// File: rtl/alu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_fsm
// Brief    : Multicycle control FSM driving ALU, memory, register-file and PC
//            strobes from a latched 32-bit instruction.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_fsm
    import alu_ctrl_fsm_pkg::*;
#(
    parameter int FP_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             alu_op,
    output logic [5:0]       func1,
    output logic [5:0]       func2,
    output logic             alu_src_imm,
    input  logic             zero,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             mem_ack,
    output logic             reg_wr,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [31:0]      r_ir;
    logic             r_zero_q;
    logic [CNT_W-1:0] r_retired;
    op_class_e        w_cls;
    logic             w_accept;
    logic             w_retire;
    logic             w_fp_load;
    logic             w_fp_done;
    logic             w_unused_ir;

    assign w_cls       = decode_class(r_ir[31:26], r_ir[5:0]);
    assign w_accept    = instr_valid && (r_state == c_ST_IDLE);
    assign w_fp_load   = (r_state == c_ST_DECODE) && (w_cls == CLS_FP);
    // Operand fields are routed to the datapath elsewhere; control ignores them.
    assign w_unused_ir = ^r_ir[25:6];

    assign w_retire = ((r_state == c_ST_EXEC)    && (w_cls == CLS_JUMP))
                   || ((r_state == c_ST_MEM)     && mem_ack && (w_cls == CLS_STORE))
                   ||  (r_state == c_ST_WB)
                   ||  (r_state == c_ST_BRANCH)
                   || ((r_state == c_ST_FPSTALL) && w_fp_done);

    alu_ctrl_fsm_fp_stall_counter #(
        .FP_LAT (FP_LAT)
    ) u_fp_stall_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (w_fp_load),
        .enable (r_state == c_ST_FPSTALL),
        .done   (w_fp_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_ir      <= '0;
            r_zero_q  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_ir <= instr;
            end
            if (r_state == c_ST_EXEC) begin
                r_zero_q <= zero;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) w_next_state = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                if (w_cls == CLS_FP)            w_next_state = c_ST_FPSTALL;
                else if (w_cls == CLS_ILLEGAL)  w_next_state = c_ST_IDLE;
                else                            w_next_state = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                case (w_cls)
                    CLS_JUMP:             w_next_state = c_ST_IDLE;
                    CLS_BRANCH:           w_next_state = c_ST_BRANCH;
                    CLS_LOAD, CLS_STORE:  w_next_state = c_ST_MEM;
                    default:              w_next_state = c_ST_WB;
                endcase
            end
            c_ST_MEM: begin
                if (mem_ack) begin
                    w_next_state = (w_cls == CLS_LOAD) ? c_ST_WB : c_ST_IDLE;
                end
            end
            c_ST_WB:      w_next_state = c_ST_IDLE;
            c_ST_BRANCH:  w_next_state = c_ST_IDLE;
            c_ST_FPSTALL: begin
                if (w_fp_done) w_next_state = c_ST_IDLE;
            end
            default:      w_next_state = c_ST_IDLE;
        endcase
    end

    // Moore outputs: a function of state and latched instruction only.
    always_comb begin
        instr_ready = (r_state == c_ST_IDLE);
        busy        = (r_state != c_ST_IDLE);
        alu_op      = 1'b0;
        func1       = 6'd0;
        func2       = 6'd0;
        alu_src_imm = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        reg_wr      = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        pc_write    = 1'b0;
        pc_src      = c_PCSRC_NONE;
        illegal     = 1'b0;
        case (r_state)
            c_ST_DECODE: begin
                illegal = (w_cls == CLS_ILLEGAL);
            end
            c_ST_EXEC: begin
                alu_op      = 1'b1;
                func1       = r_ir[5:0];
                func2       = r_ir[31:26];
                alu_src_imm = (w_cls == CLS_IMM) || (w_cls == CLS_LOAD)
                           || (w_cls == CLS_STORE);
                if (w_cls == CLS_JUMP) begin
                    pc_write = 1'b1;
                    pc_src   = c_PCSRC_JUMP;
                end
            end
            c_ST_MEM: begin
                mem_rd = (w_cls == CLS_LOAD);
                mem_wr = (w_cls == CLS_STORE);
            end
            c_ST_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = (w_cls == CLS_LOAD);
                reg_dst    = (w_cls == CLS_ALU);
            end
            c_ST_BRANCH: begin
                pc_write = r_zero_q;
                pc_src   = c_PCSRC_BRANCH;
            end
            default: ;
        endcase
    end

    assign retired = r_retired;

endmodule : alu_ctrl_fsm
`default_nettype wire

// File: tb/tb_alu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_fsm
// Brief    : Self-checking bench: per-cycle timeline model plus literal pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_fsm;

    localparam int FP_LAT = 4;
    localparam int CNT_W  = 3;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_FP = 6'h11;
    localparam logic [5:0] OP_LD = 6'h23, OP_ST = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_MULT = 6'h18, FN_DIV = 6'h1A;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

    typedef struct packed {
        logic       rdy;
        logic       aop;
        logic [5:0] f1;
        logic [5:0] f2;
        logic       imm;
        logic       mrd;
        logic       mwr;
        logic       rwr;
        logic       m2r;
        logic       rdst;
        logic       pcw;
        logic [1:0] pcs;
        logic       ill;
        logic       bsy;
    } ov_t;

    logic             clk;
    logic             reset;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             alu_op;
    logic [5:0]       func1;
    logic [5:0]       func2;
    logic             alu_src_imm;
    logic             zero;
    logic             mem_rd;
    logic             mem_wr;
    logic             mem_ack;
    logic             reg_wr;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] retired;

    alu_ctrl_fsm #(.FP_LAT(FP_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_op(alu_op), .func1(func1), .func2(func2),
        .alu_src_imm(alu_src_imm), .zero(zero), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal), .busy(busy),
        .retired(retired)
    );

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    ov_t              exp_map [int];
    logic [CNT_W-1:0] ret_change [int];
    logic [CNT_W-1:0] m_ret = '0;
    logic [CNT_W-1:0] cur_ret = '0;
    int               run_len = 0, last_run = 0, mrd_cnt = 0, ill_cnt = 0, pcw_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    function automatic ov_t idle_v();
        ov_t v;
        v     = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {op, mid, fn};
    endfunction

    task automatic pin(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Expected timeline of one instruction, starting at the DECODE cycle s.
    // Returns e, the first cycle back in IDLE, and the cycle that needs mem_ack.
    task automatic model(input logic [31:0] ins, input logic z, input int w, input int s,
                         output int e, output int ack_key);
        logic [5:0] op, fn;
        ov_t        b, v;
        bit         legal;
        op      = ins[31:26];
        fn      = ins[5:0];
        ack_key = -1;
        b       = '0;
        b.bsy   = 1'b1;
        if (op == OP_R)
            legal = fn inside {FN_SLL, FN_SRL, FN_MULT, FN_DIV, FN_ADD, FN_SUB, FN_SLT};
        else
            legal = op inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_FP, OP_LD, OP_ST};
        v = b; v.ill = !legal;
        exp_map[s] = v;
        if (!legal) begin
            e = s + 1;
            return;
        end
        if (op == OP_FP) begin
            for (int k = 1; k <= FP_LAT; k++) exp_map[s + k] = b;
            e = s + FP_LAT + 1;
        end else begin
            v = b; v.aop = 1'b1; v.f1 = fn; v.f2 = op;
            v.imm = op inside {OP_LD, OP_ST, OP_ADDI, OP_SLTI};
            if (op == OP_J) begin v.pcw = 1'b1; v.pcs = 2'b10; end
            exp_map[s + 1] = v;
            if (op == OP_J) begin
                e = s + 2;
            end else if (op == OP_BEQ || op == OP_BNE) begin
                v = b; v.pcw = z; v.pcs = 2'b01;
                exp_map[s + 2] = v;
                e = s + 3;
            end else if (op == OP_LD) begin
                for (int k = 0; k < w; k++) begin v = b; v.mrd = 1'b1; exp_map[s + 2 + k] = v; end
                v = b; v.rwr = 1'b1; v.m2r = 1'b1;
                exp_map[s + 2 + w] = v;
                e = s + 3 + w;
                ack_key = s + 1 + w;
            end else if (op == OP_ST) begin
                for (int k = 0; k < w; k++) begin v = b; v.mwr = 1'b1; exp_map[s + 2 + k] = v; end
                e = s + 2 + w;
                ack_key = s + 1 + w;
            end else begin
                v = b; v.rwr = 1'b1; v.rdst = (op == OP_R);
                exp_map[s + 2] = v;
                e = s + 3;
            end
        end
        m_ret = m_ret + 1'b1;
        ret_change[e] = m_ret;
    endtask

    // Called at posedge+2 of an IDLE cycle; offers ins for exactly one cycle.
    task automatic issue(input logic [31:0] ins, input logic z, input int w,
                         output int e, output int ak);
        instr       = ins;
        instr_valid = 1'b1;
        zero        = z;
        model(ins, z, w, cyc + 1, e, ak);
        @(posedge clk); #2;
        instr_valid = 1'b0;
        instr       = $urandom;
    endtask

    task automatic drain(input int e, input int ak, input bit junk);
        while (cyc < e) begin
            mem_ack = (cyc == ak);
            if (junk) begin
                instr_valid = 1'b1;
                instr       = mk(6'h3F, 6'h3F);
            end
            @(posedge clk); #2;
        end
        mem_ack     = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] ins, input logic z, input int w, input bit junk);
        int e, ak;
        issue(ins, z, w, e, ak);
        drain(e, ak, junk);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic realign();
        @(posedge clk); #2;
    endtask

    always @(negedge clk) begin : p_monitor
        if (mem_rd)   mrd_cnt++;
        if (illegal)  ill_cnt++;
        if (pc_write) pcw_cnt++;
        if (busy) run_len++;
        else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    always @(negedge clk) begin : p_compare
        ov_t a, e;
        if (ret_change.exists(cyc)) cur_ret = ret_change[cyc];
        e = exp_map.exists(cyc) ? exp_map[cyc] : idle_v();
        a = '{rdy: instr_ready, aop: alu_op, f1: func1, f2: func2, imm: alu_src_imm,
              mrd: mem_rd, mwr: mem_wr, rwr: reg_wr, m2r: mem_to_reg, rdst: reg_dst,
              pcw: pc_write, pcs: pc_src, ill: illegal, bsy: busy};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %h expected %h", cyc, a, e);
        end
        checks++;
        if (retired !== cur_ret) begin
            errors++;
            $display("FAIL retired cycle %0d: got %0d expected %0d", cyc, retired, cur_ret);
        end
    end

    initial begin : p_stim
        logic [5:0]       fns [6];
        logic [CNT_W-1:0] snap;
        int               m0, i0, p0, e, ak;
        fns = '{FN_SUB, FN_SLT, FN_SLL, FN_SRL, FN_MULT, FN_DIV};
        reset = 1'b0; instr_valid = 1'b0; instr = '0; zero = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        realign();
        pin("reset_instr_ready", int'(instr_ready), 1);
        pin("reset_retired", int'(retired), 0);

        run(32'h0043_0820, 1'b0, 0, 1'b0);
        settle();
        pin("radd_latency", last_run + 1, 4);
        pin("radd_retired", int'(retired), 1);
        realign();

        foreach (fns[i]) run(mk(OP_R, fns[i]), 1'b0, 0, 1'b0);
        run(mk(OP_ADDI, 6'h15), 1'b0, 0, 1'b0);
        run(mk(OP_SLTI, 6'h2A), 1'b1, 0, 1'b0);

        p0 = pcw_cnt;
        run(mk(OP_BEQ, 6'h01), 1'b1, 0, 1'b0);
        settle();
        pin("beq_taken_pcwrite", pcw_cnt - p0, 1);
        pin("beq_latency", last_run + 1, 4);
        realign();
        p0 = pcw_cnt;
        run(mk(OP_BEQ, 6'h02), 1'b0, 0, 1'b0);
        run(mk(OP_BNE, 6'h03), 1'b1, 0, 1'b0);
        settle();
        pin("branch_pair_pcwrite", pcw_cnt - p0, 1);
        realign();

        run(mk(OP_J, 6'h3F), 1'b0, 0, 1'b0);
        settle();
        pin("jump_latency", last_run + 1, 3);
        realign();

        m0 = mrd_cnt;
        run(mk(OP_LD, 6'h04), 1'b0, 4, 1'b0);
        settle();
        pin("ldrw_mem_rd_cycles", mrd_cnt - m0, 4);
        pin("ldrw_busy_cycles", last_run, 7);
        realign();

        run(mk(OP_ST, 6'h08), 1'b0, 1, 1'b0);
        settle();
        pin("strw_latency", last_run + 1, 4);
        realign();

        snap = retired;
        i0   = ill_cnt;
        run(mk(6'h3F, 6'h20), 1'b0, 0, 1'b0);
        run(mk(OP_R, 6'h3F), 1'b0, 0, 1'b0);
        settle();
        pin("illegal_pulses", ill_cnt - i0, 2);
        pin("illegal_retired_unchanged", int'(retired), int'(snap));
        pin("illegal_latency", last_run + 1, 2);
        realign();

        run(mk(OP_FP, 6'h00), 1'b0, 0, 1'b0);
        settle();
        pin("flpt_latency", last_run + 1, 2 + FP_LAT);
        realign();

        run(mk(OP_ADDI, 6'h07), 1'b0, 0, 1'b1);

        issue(mk(OP_ST, 6'h11), 1'b0, 20, e, ak);
        realign();
        realign();
        pin("strw_mem_wr_before_reset", int'(mem_wr), 1);
        for (int k = cyc; k < cyc + 64; k++) begin
            exp_map.delete(k);
            ret_change.delete(k);
        end
        ret_change[cyc] = '0;
        m_ret = '0;
        #1 reset = 1'b0;
        #1;
        pin("reset_mem_wr_drop", int'(mem_wr), 0);
        pin("reset_mid_ready", int'(instr_ready), 1);
        pin("reset_mid_busy", int'(busy), 0);
        pin("reset_mid_retired", int'(retired), 0);
        realign();
        realign();
        reset = 1'b1;
        realign();
        pin("post_reset_ready", int'(instr_ready), 1);
        run(32'h0043_0820, 1'b0, 0, 1'b0);
        settle();
        pin("post_reset_retired", int'(retired), 1);
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_ctrl_fsm
`default_nettype wire
